md_sequencer: RTL and testbench

Multi-cycle controller for the HI/LO multiply/divide resource of the 5-stage MIPS pipeline. It accepts mult/multu/div/divu issue from the E stage, sequences a fixed-latency busy window, and commits results to HI/LO on completion. It serves mthi/mtlo writes and mfhi/mflo reads. It generates the MD stall request for a D-stage instruction that touches HI/LO while the unit is occupied.

---
 rtl/md_sequencer.sv | 147 ++++++++++++++
 tb/tb_md_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, commit to HI/LO, mthi/mtlo, MD stall.
// Optional build macro MD_DIV0_FAST_EN: divide-by-zero commits after a single busy cycle.
module md_sequencer #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  mdop,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_wr,
    input  logic        hilo_sel,
    input  logic [31:0] wr_data,
    input  logic        usemd_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] hi_d;
    logic [31:0] lo_d;
    logic [3:0]  load_cnt;
    logic        div0_fast;

    logic        signed_op;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    assign load_cnt = mdop[1] ? DIV_CNT : MUL_CNT;

`ifdef MD_DIV0_FAST_EN
    assign div0_fast = mdop[1] & (src_b == 32'd0);
`else
    assign div0_fast = 1'b0;
`endif

    // Signed division works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        signed_op = ~op_q[0];
        neg_a     = signed_op & a_q[31];
        neg_b     = signed_op & b_q[31];
        ext_a     = {{32{neg_a}}, a_q};
        ext_b     = {{32{neg_b}}, b_q};
        prod      = ext_a * ext_b;
        mag_a     = neg_a ? (32'd0 - a_q) : a_q;
        mag_b     = neg_b ? (32'd0 - b_q) : b_q;
        quo_u     = 32'd0;
        rem_u     = 32'd0;
        if (b_q != 32'd0) begin
            quo_u = mag_a / mag_b;
            rem_u = mag_a % mag_b;
        end
        hi_d = prod[63:32];
        lo_d = prod[31:0];
        if (op_q[1]) begin
            if (b_q == 32'd0) begin
                hi_d = a_q;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = neg_a ? (32'd0 - rem_u) : rem_u;
                lo_d = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
            end
        end
    end

    // RUN hands over to COMMIT as the counter reaches 0, so RUN + COMMIT spans exactly LAT cycles.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q  <= mdop;
                        a_q   <= src_a;
                        b_q   <= src_b;
                        cnt_q <= div0_fast ? 4'd0 : load_cnt;
                        if (div0_fast || load_cnt == 4'd0) begin
                            state_q <= COMMIT;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (hilo_wr) begin
                        if (hilo_sel) begin
                            hi_q <= wr_data;
                        end else begin
                            lo_q <= wr_data;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign stall_md = usemd_d & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign rd_data  = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: randomized MD ops checked against an arithmetic reference model.
// Honours MD_DIV0_FAST_EN when computing expected divide-by-zero latency.
module tb_md_sequencer;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk;
    logic        clr;
    logic        start;
    logic [1:0]  mdop;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_wr;
    logic        hilo_sel;
    logic [31:0] wr_data;
    logic        usemd_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    md_sequencer #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk),
        .clr(clr),
        .start(start),
        .mdop(mdop),
        .src_a(src_a),
        .src_b(src_b),
        .hilo_wr(hilo_wr),
        .hilo_sel(hilo_sel),
        .wr_data(wr_data),
        .usemd_d(usemd_d),
        .busy(busy),
        .stall_md(stall_md),
        .hi(hi),
        .lo(lo),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    int          checks = 0;
    int          errors = 0;
    int          busyCnt = 0;
    logic        prevBusy = 1'b0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sp;
        longint      q;
        longint      r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.lat = op[1] ? DIV_LAT : MUL_LAT;
        case (op)
            2'b00: begin
                sp = sa * sb;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
`ifdef MD_DIV0_FAST_EN
        if (op[1] && b == 32'd0) e.lat = 1;
`endif
        return e;
    endfunction

    // Monitor: every busy falling edge is a commit; compare it with the oldest expectation.
    always @(negedge clk) begin
        if (!clr) begin
            busyCnt  = 0;
            prevBusy = 1'b0;
        end else begin
            if (busy) begin
                busyCnt++;
            end else if (prevBusy) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedCommit: got hi=0x%08h lo=0x%08h, expected no commit", hi, lo);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("commitHi", hi, monE.hi);
                    checkOutput("commitLo", lo, monE.lo);
                    checkOutput("busyCycles", 32'(busyCnt), 32'(monE.lat));
                end
                busyCnt = 0;
            end
            prevBusy = busy;
        end
    end

    task automatic waitDone();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0) break;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL commitTimeout: got %0d pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkReadback();
        hilo_sel = 1'b1;
        #1 checkOutput("rdDataHi", rd_data, modelHi);
        hilo_sel = 1'b0;
        #1 checkOutput("rdDataLo", rd_data, modelLo);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit withWr, input bit disturb);
        exp_t e;
        e = refModel(op, a, b);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b1;
        mdop  = op;
        src_a = a;
        src_b = b;
        if (withWr) begin
            hilo_wr  = 1'b1;
            hilo_sel = 1'b1;
            wr_data  = 32'h0000_1234;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        hilo_wr = 1'b0;
        // A start or write arriving mid-operation must leave the result untouched.
        if (disturb) begin
            start    = 1'b1;
            mdop     = 2'($urandom_range(0, 3));
            src_a    = $urandom;
            src_b    = $urandom;
            hilo_wr  = 1'b1;
            hilo_sel = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            @(posedge clk);
            #1;
            start   = 1'b0;
            hilo_wr = 1'b0;
        end
        waitDone();
        modelHi = e.hi;
        modelLo = e.lo;
    endtask

    task automatic writeHilo(input logic sel, input logic [31:0] data);
        @(posedge clk);
        #1;
        hilo_wr  = 1'b1;
        hilo_sel = sel;
        wr_data  = data;
        @(posedge clk);
        #1;
        hilo_wr = 1'b0;
        if (sel) modelHi = data;
        else     modelLo = data;
        checkReadback();
    endtask

    task automatic stallTest();
        exp_t e;
        e = refModel(2'b00, 32'h0000_0003, 32'h0000_0004);
        expQ.push_back(e);
        usemd_d = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        mdop  = 2'b00;
        src_a = 32'h0000_0003;
        src_b = 32'h0000_0004;
        @(negedge clk);
        checkOutput("stallStartCycle", {31'd0, stall_md}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < e.lat; i++) begin
            @(negedge clk);
            checkOutput("stallBusyCycle", {31'd0, stall_md}, 32'd1);
        end
        @(negedge clk);
        checkOutput("stallAfterBusy", {31'd0, stall_md}, 32'd0);
        usemd_d = 1'b0;
        waitDone();
        modelHi = e.hi;
        modelLo = e.lo;
    endtask

    task automatic resetMidOpTest();
        @(posedge clk);
        #1;
        start = 1'b1;
        mdop  = 2'b00;
        src_a = 32'h0000_1111;
        src_b = 32'h0000_2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortHi", hi, 32'd0);
        checkOutput("abortLo", lo, 32'd0);
        @(negedge clk);
        #1;
        clr = 1'b1;
        modelHi = 32'd0;
        modelLo = 32'd0;
        repeat (15) @(negedge clk);
        #1;
        checkOutput("noLateCommitBusy", {31'd0, busy}, 32'd0);
        checkOutput("noLateCommitHi", hi, 32'd0);
        checkOutput("noLateCommitLo", lo, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        clr      = 1'b0;
        start    = 1'b0;
        mdop     = 2'b00;
        src_a    = 32'd0;
        src_b    = 32'd0;
        hilo_wr  = 1'b0;
        hilo_sel = 1'b0;
        wr_data  = 32'd0;
        usemd_d  = 1'b0;
        #12;
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetHi", hi, 32'd0);
        checkOutput("resetLo", lo, 32'd0);
        checkOutput("resetStall", {31'd0, stall_md}, 32'd0);
        @(negedge clk);
        clr = 1'b1;

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        checkReadback();
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        checkReadback();
        applyStimulus(2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
        checkReadback();
        applyStimulus(2'b11, 32'h0000_0009, 32'h0000_0000, 1'b0, 1'b1);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checkReadback();
        writeHilo(1'b1, 32'hCAFE_0001);
        writeHilo(1'b0, 32'hBEEF_0002);
        applyStimulus(2'b00, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        checkReadback();
        stallTest();

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) writeHilo(1'($urandom_range(0, 1)), $urandom);
            applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkReadback();
        end

        resetMidOpTest();
        writeHilo(1'b1, 32'h0000_5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
